// File: rtl/flush_ctrl_pkg.sv
// Shared state encoding, reset PC and redirect-target helper for the
// writeback-driven flush/redirect controller.
package flush_ctrl_pkg;

    typedef enum logic [1:0] {
        FLUSH_IDLE = 2'd0,
        FLUSH      = 2'd1,
        DRAIN      = 2'd2,
        REDIRECT   = 2'd3
    } flush_state_e;

    localparam logic [31:0] DEFAULT_RST_PC = 32'h1c00_0000;
    localparam logic [31:0] INST_BYTES     = 32'd4;

    // Refetch resumes at the instruction after the one in WB; wraps at 2^32.
    function automatic logic [31:0] refetch_target(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_outstd_cnt.sv
// Up/down saturating counter with a parallel load, used to track in-flight
// instruction fetches and the subset of them that must be discarded.
module fetch_outstd_cnt #(
    parameter int OUTSTD_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [OUTSTD_W-1:0] load_val_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [OUTSTD_W-1:0] cnt_o,
    output logic [OUTSTD_W-1:0] cnt_next_o
);

    localparam logic [OUTSTD_W-1:0] CNT_MAX = '1;

    logic [OUTSTD_W-1:0] cnt_q;
    logic [OUTSTD_W-1:0] cnt_d;

    // NOTE: cnt_d takes its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + OUTSTD_W'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - OUTSTD_W'(1);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/flush_ctrl.sv
// Sequences WB-raised flushes: capture event and target, pulse flush_all,
// drain squashed fetch responses, then hand the new PC to IF.
module flush_ctrl
    import flush_ctrl_pkg::*;
#(
    parameter int          OUTSTD_W = 2,
    parameter logic [31:0] RST_PC   = DEFAULT_RST_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic        wb_ecode_tlbr,
    input  logic        ertn_flush,
    input  logic        wb_refetch_flush,
    input  logic [31:0] wb_pc,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic [31:0] csr_era,
    input  logic        inst_req,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        flush_all,
    output logic        fs_req_allow,
    output logic        fs_discard,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        ctrl_busy
);

    localparam logic [OUTSTD_W-1:0] OUTSTD_MAX = '1;

    flush_state_e        state_q, state_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;
    logic [31:0]         event_target;
    logic                event_any;
    logic                load_discard;
    logic                outstd_inc;
    logic [OUTSTD_W-1:0] outstd_cnt, outstd_cnt_next;
    logic [OUTSTD_W-1:0] discard_cnt, discard_cnt_next;

    assign event_any = wb_ex | ertn_flush | wb_refetch_flush;

    always_comb begin
        if (wb_ex) begin
            event_target = wb_ecode_tlbr ? csr_tlbrentry : csr_eentry;
        end else if (ertn_flush) begin
            event_target = csr_era;
        end else begin
            event_target = refetch_target(wb_pc);
        end
    end

    assign fs_req_allow = ((state_q == FLUSH_IDLE) || ((state_q == REDIRECT) && redirect_ready))
                          && (outstd_cnt != OUTSTD_MAX);
    assign outstd_inc   = inst_req & inst_addr_ok & fs_req_allow;
    assign fs_discard   = inst_data_ok & (discard_cnt != '0);

    fetch_outstd_cnt #(.OUTSTD_W(OUTSTD_W)) u_outstd_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (outstd_inc),
        .dec_i      (inst_data_ok),
        .cnt_o      (outstd_cnt),
        .cnt_next_o (outstd_cnt_next)
    );

    // Loading the post-update outstanding count means a response landing in
    // FLUSH has already retired and is not counted as squashed again.
    fetch_outstd_cnt #(.OUTSTD_W(OUTSTD_W)) u_discard_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_discard),
        .load_val_i (outstd_cnt_next),
        .inc_i      (1'b0),
        .dec_i      (fs_discard),
        .cnt_o      (discard_cnt),
        .cnt_next_o (discard_cnt_next)
    );

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        load_discard  = 1'b0;
        unique case (state_q)
            FLUSH_IDLE: begin
                if (event_any) begin
                    state_d       = FLUSH;
                    redirect_pc_d = event_target;
                end
            end
            FLUSH: begin
                load_discard = 1'b1;
                state_d      = DRAIN;
            end
            DRAIN: begin
                if (discard_cnt_next == '0) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = FLUSH_IDLE;
                end
            end
            default: state_d = FLUSH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FLUSH_IDLE;
            redirect_pc_q <= RST_PC;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign flush_all      = (state_q == FLUSH);
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign ctrl_busy      = (state_q != FLUSH_IDLE);

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed self-checking bench for flush_ctrl: latency, target priority,
// discard accounting, fetch-counter saturation and asynchronous reset.
module tb_flush_ctrl;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam logic [31:0] EENTRY = 32'h1c00_8000;
    localparam logic [31:0] TLBRE  = 32'h1c00_f000;
    localparam logic [31:0] ERA    = 32'h1c00_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex, wb_ecode_tlbr, ertn_flush, wb_refetch_flush;
    logic [31:0] wb_pc, csr_eentry, csr_tlbrentry, csr_era;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic        flush_all, fs_req_allow, fs_discard, redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        ctrl_busy;

    int total = 0;
    int bad   = 0;
    int model_outstd = 0;
    bit stray_ok = 1'b0;

    always #5 clk = ~clk;

    flush_ctrl #(.OUTSTD_W(2), .RST_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_ex            (wb_ex),
        .wb_ecode_tlbr    (wb_ecode_tlbr),
        .ertn_flush       (ertn_flush),
        .wb_refetch_flush (wb_refetch_flush),
        .wb_pc            (wb_pc),
        .csr_eentry       (csr_eentry),
        .csr_tlbrentry    (csr_tlbrentry),
        .csr_era          (csr_era),
        .inst_req         (inst_req),
        .inst_addr_ok     (inst_addr_ok),
        .inst_data_ok     (inst_data_ok),
        .flush_all        (flush_all),
        .fs_req_allow     (fs_req_allow),
        .fs_discard       (fs_discard),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready),
        .ctrl_busy        (ctrl_busy)
    );

    // Bus protocol watchdog: a response with nothing in flight is a stimulus bug.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_outstd <= 0;
        end else begin
            if (inst_data_ok && (model_outstd == 0) && !stray_ok)
                $error("protocol: inst_data_ok with no outstanding request");
            model_outstd <= model_outstd
                          + ((inst_req && inst_addr_ok && fs_req_allow) ? 1 : 0)
                          - ((inst_data_ok && (model_outstd != 0)) ? 1 : 0);
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({flush_all, fs_req_allow, fs_discard, redirect_valid, ctrl_busy} !== 5'b01000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 01000",
                     {flush_all, fs_req_allow, fs_discard, redirect_valid, ctrl_busy});
        end
        total++;
        if (redirect_pc !== RST_PC) begin
            bad++; $display("FAIL reset_pc: got %h want %h", redirect_pc, RST_PC);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exception();
        csr_eentry = EENTRY;
        wb_ex = 1'b1;
        @(negedge clk); wb_ex = 1'b0; #1;
        total++;
        if (flush_all !== 1'b1 || fs_req_allow !== 1'b0) begin
            bad++; $display("FAIL exc_flush: flush_all=%b allow=%b want 1/0", flush_all, fs_req_allow);
        end
        @(negedge clk); #1;
        total++;
        if (flush_all !== 1'b0 || redirect_valid !== 1'b0 || ctrl_busy !== 1'b1) begin
            bad++; $display("FAIL exc_drain: flush=%b rv=%b busy=%b want 0/0/1", flush_all, redirect_valid, ctrl_busy);
        end
        @(negedge clk); #1;
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== EENTRY) begin
            bad++; $display("FAIL exc_redirect: rv=%b pc=%h want 1/%h", redirect_valid, redirect_pc, EENTRY);
        end
        redirect_ready = 1'b1; inst_req = 1'b1; inst_addr_ok = 1'b1; #1;
        total++;
        if (fs_req_allow !== 1'b1) begin
            bad++; $display("FAIL exc_allow_on_ready: got %b want 1", fs_req_allow);
        end
        @(negedge clk);
        redirect_ready = 1'b0; inst_req = 1'b0; inst_addr_ok = 1'b0; #1;
        total++;
        if (ctrl_busy !== 1'b0 || redirect_valid !== 1'b0 || fs_req_allow !== 1'b1) begin
            bad++; $display("FAIL exc_idle: busy=%b rv=%b allow=%b want 0/0/1", ctrl_busy, redirect_valid, fs_req_allow);
        end
        inst_data_ok = 1'b1; #1;
        total++;
        if (fs_discard !== 1'b0) begin
            bad++; $display("FAIL exc_keep_new_fetch: fs_discard=%b want 0", fs_discard);
        end
        @(negedge clk); inst_data_ok = 1'b0;
    endtask

    task automatic test_tlbr_drain();
        inst_req = 1'b1; inst_addr_ok = 1'b1;
        @(negedge clk); @(negedge clk);
        inst_req = 1'b0; inst_addr_ok = 1'b0;
        csr_tlbrentry = TLBRE; wb_ex = 1'b1; wb_ecode_tlbr = 1'b1;
        @(negedge clk); wb_ex = 1'b0; wb_ecode_tlbr = 1'b0; #1;
        total++;
        if (flush_all !== 1'b1 || fs_req_allow !== 1'b0) begin
            bad++; $display("FAIL tlbr_flush: flush=%b allow=%b want 1/0", flush_all, fs_req_allow);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); inst_data_ok = 1'b1; #1;
            total++;
            if (fs_discard !== 1'b1 || redirect_valid !== 1'b0 || fs_req_allow !== 1'b0) begin
                bad++; $display("FAIL tlbr_discard%0d: disc=%b rv=%b allow=%b want 1/0/0",
                                i, fs_discard, redirect_valid, fs_req_allow);
            end
        end
        @(negedge clk); inst_data_ok = 1'b0; #1;
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== TLBRE) begin
            bad++; $display("FAIL tlbr_redirect: rv=%b pc=%h want 1/%h", redirect_valid, redirect_pc, TLBRE);
        end
        redirect_ready = 1'b1;
        @(negedge clk); redirect_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        csr_era = ERA; wb_pc = 32'h1c00_0040;
        wb_ex = 1'b1; ertn_flush = 1'b1; wb_refetch_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (flush_all === 1'b1) pulses++;
            csr_eentry = 32'h1c00_9000;
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL simul_pulses: got %0d want 1", pulses);
        end
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== EENTRY) begin
            bad++; $display("FAIL simul_target: rv=%b pc=%h want 1/%h", redirect_valid, redirect_pc, EENTRY);
        end
        wb_ex = 1'b0; ertn_flush = 1'b0; wb_refetch_flush = 1'b0; redirect_ready = 1'b1;
        @(negedge clk); redirect_ready = 1'b0; #1;
        total++;
        if (ctrl_busy !== 1'b0) begin
            bad++; $display("FAIL simul_idle: busy=%b want 0", ctrl_busy);
        end
        csr_eentry = EENTRY;
    endtask

    // One event on an idle bus; checks latency, target, hold-without-ready, return to idle.
    task automatic run_event(input logic ex, input logic tlbr, input logic ertn,
                             input logic refetch, input logic [31:0] exp_pc, input string name);
        int n = 0;
        wb_ex = ex; wb_ecode_tlbr = tlbr; ertn_flush = ertn; wb_refetch_flush = refetch;
        @(negedge clk);
        wb_ex = 1'b0; wb_ecode_tlbr = 1'b0; ertn_flush = 1'b0; wb_refetch_flush = 1'b0;
        while (redirect_valid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        total++;
        if (redirect_valid !== 1'b1 || n != 2) begin
            bad++; $display("FAIL %s_latency: rv=%b cycles=%0d want 1/2", name, redirect_valid, n);
        end
        total++;
        if (redirect_pc !== exp_pc) begin
            bad++; $display("FAIL %s_pc: got %h want %h", name, redirect_pc, exp_pc);
        end
        @(negedge clk);
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
            bad++; $display("FAIL %s_hold: rv=%b pc=%h want 1/%h", name, redirect_valid, redirect_pc, exp_pc);
        end
        redirect_ready = 1'b1;
        @(negedge clk); redirect_ready = 1'b0;
        total++;
        if (ctrl_busy !== 1'b0) begin
            bad++; $display("FAIL %s_idle: busy=%b want 0", name, ctrl_busy);
        end
    endtask

    task automatic test_saturation();
        inst_req = 1'b1; inst_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (fs_req_allow !== 1'b1) begin
                bad++; $display("FAIL sat_allow%0d: got %b want 1", i, fs_req_allow);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (fs_req_allow !== 1'b0) begin
            bad++; $display("FAIL sat_full: got %b want 0", fs_req_allow);
        end
        @(negedge clk); #1;
        total++;
        if (fs_req_allow !== 1'b0) begin
            bad++; $display("FAIL sat_blocked_not_counted: got %b want 0", fs_req_allow);
        end
        inst_req = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b1;
        @(negedge clk); #1;
        total++;
        if (fs_req_allow !== 1'b1 || fs_discard !== 1'b0) begin
            bad++; $display("FAIL sat_release: allow=%b disc=%b want 1/0", fs_req_allow, fs_discard);
        end
        @(negedge clk); @(negedge clk);
        inst_data_ok = 1'b0;
    endtask

    task automatic test_async_reset();
        inst_req = 1'b1; inst_addr_ok = 1'b1;
        @(negedge clk); @(negedge clk);
        inst_req = 1'b0; inst_addr_ok = 1'b0;
        csr_tlbrentry = TLBRE; wb_ex = 1'b1; wb_ecode_tlbr = 1'b1;
        @(negedge clk); wb_ex = 1'b0; wb_ecode_tlbr = 1'b0;
        @(negedge clk); #1;
        total++;
        if (ctrl_busy !== 1'b1 || flush_all !== 1'b0 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL arst_in_drain: busy=%b flush=%b rv=%b want 1/0/0", ctrl_busy, flush_all, redirect_valid);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({flush_all, fs_req_allow, fs_discard, redirect_valid, ctrl_busy} !== 5'b01000) begin
            bad++;
            $display("FAIL arst_flags: got %b want 01000",
                     {flush_all, fs_req_allow, fs_discard, redirect_valid, ctrl_busy});
        end
        total++;
        if (redirect_pc !== RST_PC) begin
            bad++; $display("FAIL arst_pc: got %h want %h", redirect_pc, RST_PC);
        end
        @(negedge clk);
        reset = 1'b0; stray_ok = 1'b1; inst_data_ok = 1'b1; #1;
        total++;
        if (fs_discard !== 1'b0 || fs_req_allow !== 1'b1) begin
            bad++; $display("FAIL arst_no_discard: disc=%b allow=%b want 0/1", fs_discard, fs_req_allow);
        end
        @(negedge clk); inst_data_ok = 1'b0; stray_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wb_ex = 1'b0; wb_ecode_tlbr = 1'b0; ertn_flush = 1'b0; wb_refetch_flush = 1'b0;
        wb_pc = 32'h0; csr_eentry = EENTRY; csr_tlbrentry = TLBRE; csr_era = ERA;
        inst_req = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; redirect_ready = 1'b0;

        test_reset();
        test_exception();
        test_tlbr_drain();
        test_simultaneous();
        wb_pc = 32'hffff_fffc;
        run_event(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, "refetch_wrap");
        wb_pc = 32'h1c00_0200;
        run_event(1'b0, 1'b0, 1'b0, 1'b1, 32'h1c00_0204, "refetch");
        run_event(1'b0, 1'b0, 1'b1, 1'b1, ERA, "ertn_over_refetch");
        run_event(1'b1, 1'b1, 1'b1, 1'b0, TLBRE, "tlbr_over_ertn");
        test_saturation();
        test_async_reset();
        run_event(1'b1, 1'b0, 1'b0, 1'b0, EENTRY, "post_reset_exc");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
